// File: rtl/step_clk_ctrl_if.sv
// Control/status bundle for the step/run clock-enable controller.
// The master side drives the mode and button inputs; the slave side returns the enable and status.
interface step_clk_ctrl_if;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt_req;
  logic        cnt_clr;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  modport master (
    output mode, step_btn, halt_req, cnt_clr,
    input  cpu_en, halted, state, cycle_cnt
  );

  modport slave (
    input  mode, step_btn, halt_req, cnt_clr,
    output cpu_en, halted, state, cycle_cnt
  );
endinterface

// File: rtl/step_clk_ctrl.sv
// Run/halt/single-step CPU clock-enable generator with pulse counter.
// Optional step-button debounce is enabled by defining STEP_DEBOUNCE_EN.
module step_clk_ctrl #(
  parameter int unsigned DIV_N      = 10,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic            CLK_in,
  input  logic            rst_n,
  step_clk_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HALT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_HOLD = 2'b10
  } state_e;

  localparam logic [31:0] DIV_LAST = 32'(DIV_N - 32'd1);

  state_e      state_r;
  logic        cpu_en_r;
  logic        halted_r;
  logic [31:0] cycle_cnt_r;
  logic [31:0] div_cnt_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        press_s;
  logic [1:0]  mode_eff_s;

  // Two-flop synchronizer for the raw button level
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.step_btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam logic [31:0] DEB_FULL = 32'(DEB_CYCLES);
  localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 32'd1);

  logic [31:0] deb_cnt_r;

  // Counts consecutive high samples; saturates so one press fires only once
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r <= 32'd0;
    end else if (!sync2_r) begin
      deb_cnt_r <= 32'd0;
    end else if (deb_cnt_r != DEB_FULL) begin
      deb_cnt_r <= deb_cnt_r + 32'd1;
    end
  end

  assign press_s = sync2_r && (deb_cnt_r == DEB_LAST);
`else
  logic prev_r;

  // Previous synchronized level for rising-edge detection
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sync2_r;
    end
  end

  assign press_s = sync2_r & ~prev_r;
`endif

  // Reserved mode 11 behaves as halt
  always_comb begin
    mode_eff_s = bus.mode;
    if (bus.mode == 2'b11) begin
      mode_eff_s = 2'b00;
    end else begin
      mode_eff_s = bus.mode;
    end
  end

  // Main FSM with registered enable and run divider
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_HALT;
      cpu_en_r  <= 1'b0;
      div_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        ST_HALT: begin
          div_cnt_r <= 32'd0;
          if (mode_eff_s == 2'b01 && !halted_r) begin
            state_r  <= ST_RUN;
            cpu_en_r <= 1'b0;
          end else if (mode_eff_s == 2'b10 && press_s) begin
            state_r  <= ST_STEP_HOLD;
            cpu_en_r <= 1'b1;
          end else begin
            cpu_en_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // A stop request wins over a tick falling due in the same cycle
          if (mode_eff_s != 2'b01 || bus.halt_req) begin
            state_r   <= ST_HALT;
            cpu_en_r  <= 1'b0;
            div_cnt_r <= 32'd0;
          end else if (div_cnt_r == DIV_LAST) begin
            cpu_en_r  <= 1'b1;
            div_cnt_r <= 32'd0;
          end else begin
            cpu_en_r  <= 1'b0;
            div_cnt_r <= div_cnt_r + 32'd1;
          end
        end
        ST_STEP_HOLD: begin
          cpu_en_r <= 1'b0;
          if (!sync2_r) begin
            state_r <= ST_HALT;
          end else begin
            state_r <= ST_STEP_HOLD;
          end
        end
        default: begin
          state_r   <= ST_HALT;
          cpu_en_r  <= 1'b0;
          div_cnt_r <= 32'd0;
        end
      endcase
    end
  end

  // Sticky halt flag: set when halt_req ends run mode, cleared only in halt mode
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (state_r == ST_RUN && bus.halt_req) begin
      halted_r <= 1'b1;
    end else if (mode_eff_s == 2'b00) begin
      halted_r <= 1'b0;
    end
  end

  // Pulse counter; clear has priority over increment
  always_ff @(posedge CLK_in or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= 32'd0;
    end else if (bus.cnt_clr) begin
      cycle_cnt_r <= 32'd0;
    end else if (cpu_en_r) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end
  end

  assign bus.cpu_en    = cpu_en_r;
  assign bus.halted    = halted_r;
  assign bus.state     = state_r;
  assign bus.cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Self-checking bench for step_clk_ctrl: two instances (DIV_N=10 and DIV_N=1) against a behavioural model.
module tb_step_clk_ctrl;

  localparam int DIV0 = 10;
  localparam int DIV1 = 1;
`ifdef STEP_DEBOUNCE_EN
  localparam int DEB_EFF = 16;
`else
  localparam int DEB_EFF = 1;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  step_clk_ctrl_if bus0 ();
  step_clk_ctrl_if bus1 ();

  step_clk_ctrl #(.DIV_N(DIV0), .DEB_CYCLES(16)) dut0 (.CLK_in(clk_in), .rst_n(rst_n), .bus(bus0));
  step_clk_ctrl #(.DIV_N(DIV1), .DEB_CYCLES(16)) dut1 (.CLK_in(clk_in), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per instance
  int          m_div [2] = '{DIV0, DIV1};
  int          m_state [2];
  int          m_age [2];
  logic        m_en [2];
  logic        m_halted [2];
  logic [31:0] m_cnt [2];
  bit          hist [$];
  int          pulses [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_state[u] = 0; m_age[u] = 0; m_en[u] = 1'b0; m_halted[u] = 1'b0; m_cnt[u] = 32'd0;
    end
    hist.delete();
  endtask

  // One rising edge of behaviour, from the rules in plain arithmetic
  task automatic model_step(input logic [1:0] md, input logic btn, input logic hr, input logic clr);
    int idx, lvl, rl, mde;
    bit press, nh;
    logic [31:0] ncnt;
    hist.push_back(btn);
    if (hist.size() > 40) void'(hist.pop_front());
    idx = hist.size() - 3;
    lvl = (idx >= 0) ? int'(hist[idx]) : 0;
    rl = 0;
    for (int j = idx; j >= 0 && rl <= DEB_EFF; j--) begin
      if (hist[j]) rl++;
      else break;
    end
    press = (rl == DEB_EFF);
    mde = (md == 2'b11) ? 0 : int'(md);
    for (int u = 0; u < 2; u++) begin
      ncnt = clr ? 32'd0 : (m_en[u] ? m_cnt[u] + 32'd1 : m_cnt[u]);
      nh = (m_state[u] == 1 && hr) ? 1'b1 : ((mde == 0) ? 1'b0 : m_halted[u]);
      if (m_state[u] == 0) begin
        if (mde == 1 && !m_halted[u]) begin
          m_state[u] = 1; m_age[u] = 0; m_en[u] = 1'b0;
        end else if (mde == 2 && press) begin
          m_state[u] = 2; m_en[u] = 1'b1;
        end else begin
          m_en[u] = 1'b0;
        end
      end else if (m_state[u] == 1) begin
        if (mde != 1 || hr) begin
          m_state[u] = 0; m_en[u] = 1'b0;
        end else begin
          m_age[u]++;
          m_en[u] = ((m_age[u] % m_div[u]) == 0);
        end
      end else begin
        m_en[u] = 1'b0;
        if (lvl == 0) m_state[u] = 0;
      end
      m_halted[u] = nh;
      m_cnt[u] = ncnt;
    end
  endtask

  task automatic compare();
    chk("en0",     32'(bus0.cpu_en),    32'(m_en[0]));
    chk("halted0", 32'(bus0.halted),    32'(m_halted[0]));
    chk("state0",  32'(bus0.state),     32'(m_state[0]));
    chk("cnt0",    bus0.cycle_cnt,      m_cnt[0]);
    chk("en1",     32'(bus1.cpu_en),    32'(m_en[1]));
    chk("halted1", 32'(bus1.halted),    32'(m_halted[1]));
    chk("state1",  32'(bus1.state),     32'(m_state[1]));
    chk("cnt1",    bus1.cycle_cnt,      m_cnt[1]);
  endtask

  task automatic set_in(input logic [1:0] md, input logic btn, input logic hr, input logic clr);
    bus0.mode = md; bus0.step_btn = btn; bus0.halt_req = hr; bus0.cnt_clr = clr;
    bus1.mode = md; bus1.step_btn = btn; bus1.halt_req = hr; bus1.cnt_clr = clr;
  endtask

  // Drive at negedge, model at posedge, compare 1 time unit later, return at next negedge
  task automatic cyc(input logic [1:0] md, input logic btn, input logic hr, input logic clr);
    set_in(md, btn, hr, clr);
    @(posedge clk_in);
    model_step(md, btn, hr, clr);
    #1;
    compare();
    @(negedge clk_in);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en0"},  32'(bus0.cpu_en), 32'd0);
    chk({tag, "_hl0"},  32'(bus0.halted), 32'd0);
    chk({tag, "_st0"},  32'(bus0.state),  32'd0);
    chk({tag, "_cnt0"}, bus0.cycle_cnt,   32'd0);
    chk({tag, "_en1"},  32'(bus1.cpu_en), 32'd0);
    chk({tag, "_cnt1"}, bus1.cycle_cnt,   32'd0);
  endtask

  initial begin
    int last;
    logic [1:0] rmode;
    logic rbtn;
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // run: pulses 10, 20, 30 edges after entry
    pulses.delete();
    for (int i = 0; i < 35; i++) begin
      cyc(2'b01, 1'b0, 1'b0, 1'b0);
      if (bus0.cpu_en) pulses.push_back(i);
    end
    chk("run_npulse", 32'(pulses.size()), 32'd3);
    chk("run_p1", 32'(pulses[0]), 32'd10);
    chk("run_p2", 32'(pulses[1]), 32'd20);
    chk("run_p3", 32'(pulses[2]), 32'd30);
    chk("run_cnt", bus0.cycle_cnt, 32'd3);

    // halt_req coincident with the tick due 40 edges after entry
    repeat (5) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b1, 1'b0);
    chk("halt_no_en", 32'(bus0.cpu_en), 32'd0);
    chk("halt_flag",  32'(bus0.halted), 32'd1);
    chk("halt_state", 32'(bus0.state),  32'd0);
    repeat (5) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    chk("halt_blocks_run", 32'(bus0.state), 32'd0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("halt_cleared", 32'(bus0.halted), 32'd0);
    pulses.delete();
    for (int i = 0; i < 12; i++) begin
      cyc(2'b01, 1'b0, 1'b0, 1'b0);
      if (bus0.cpu_en) pulses.push_back(i);
    end
    chk("resume_npulse", 32'(pulses.size()), 32'd1);
    chk("resume_p1", 32'(pulses[0]), 32'd10);

    // single step with the button held for 50 cycles
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(2'b10, 1'b0, 1'b0, 1'b0);
    pulses.delete();
    for (int i = 0; i < 50; i++) begin
      cyc(2'b10, 1'b1, 1'b0, 1'b0);
      if (bus0.cpu_en) pulses.push_back(i);
    end
    chk("step_npulse", 32'(pulses.size()), 32'd1);
    chk("step_at", 32'(pulses[0]), 32'(1 + DEB_EFF));
    chk("step_hold", 32'(bus0.state), 32'd2);
    repeat (5) cyc(2'b10, 1'b0, 1'b0, 1'b0);
    chk("step_release", 32'(bus0.state), 32'd0);

    // button high 10, low 1, high 20
    pulses.delete();
    for (int t = 0; t < 36; t++) begin
      cyc(2'b10, (t < 10 || (t >= 11 && t < 31)) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (bus0.cpu_en) pulses.push_back(t);
    end
    last = (pulses.size() > 0) ? pulses[$] : -1;
    chk("bounce_npulse", 32'(pulses.size()), (DEB_EFF == 1) ? 32'd2 : 32'd1);
    chk("bounce_last", 32'(last), 32'(12 + DEB_EFF));

    // press dropped when mode leaves 10 on the cycle it would fire
    pulses.delete();
    for (int t = 0; t < DEB_EFF + 6; t++) begin
      cyc((t == 1 + DEB_EFF) ? 2'b00 : 2'b10, 1'b1, 1'b0, 1'b0);
      if (bus0.cpu_en) pulses.push_back(t);
    end
    chk("drop_npulse", 32'(pulses.size()), 32'd0);
    repeat (4) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-run
    repeat (15) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_state", 32'(bus0.state), 32'd0);

    // counter wrap from all-ones
    force dut0.cycle_cnt_r = 32'hFFFF_FFFF;
    m_cnt[0] = 32'hFFFF_FFFF;
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    release dut0.cycle_cnt_r;
    chk("cnt_preload", bus0.cycle_cnt, 32'hFFFF_FFFF);
    for (int t = 0; t < DEB_EFF + 3; t++) cyc(2'b10, 1'b1, 1'b0, 1'b0);
    chk("cnt_wrap", bus0.cycle_cnt, 32'd0);
    repeat (4) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // cnt_clr while cpu_en is high (DIV_N=1 instance)
    repeat (4) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    chk("div1_en", 32'(bus1.cpu_en), 32'd1);
    cyc(2'b01, 1'b0, 1'b0, 1'b1);
    chk("clr_with_en", bus1.cycle_cnt, 32'd0);
    repeat (2) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    rmode = 2'b00;
    rbtn  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) rmode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) rbtn = ~rbtn;
      cyc(rmode, rbtn, ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_clk_ctrl.md
STEP_CLK_CTRL -- requirements
Module: step_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_N, default 10: CLK_in cycles per cpu_en pulse in run mode; legal 1..2^32-1.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: stable-high cycles required for a step press; used only when STEP_DEBOUNCE_EN is defined.
REQ-003 SHALL have port CLK_in, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mode, input, 2: 00 halt, 01 run, 10 step, 11 reserved (treated as 00).
REQ-006 SHALL have port step_btn, input, 1: raw asynchronous single-step button level.
REQ-007 SHALL have port halt_req, input, 1: CPU-side stop request, sampled each cycle.
REQ-008 SHALL have port cnt_clr, input, 1: synchronous clear of cycle_cnt.
REQ-009 SHALL have port cpu_en, output, 1: registered one-cycle CPU clock-enable pulse.
REQ-010 SHALL have port halted, output, 1: sticky flag showing that halt_req stopped run mode.
REQ-011 SHALL have port state, output, 2: current FSM state encoding (HALT=00, RUN=01, STEP_HOLD=10).
REQ-012 SHALL have port cycle_cnt, output, 32: count of cpu_en pulses issued.

Function
REQ-013 SHALL pass step_btn through a 2-flop synchronizer; only the synchronized level is used internally.
REQ-014 SHALL implement FSM states HALT, RUN and STEP_HOLD.
REQ-015 SHALL go HALT->RUN when mode==01 and halted==0.
REQ-016 SHALL go RUN->HALT when mode!=01 or halt_req==1.
REQ-017 SHALL, in HALT with mode==10 on a detected step press, assert cpu_en for exactly one cycle and go to STEP_HOLD.
REQ-018 SHALL go STEP_HOLD->HALT only once the synchronized step_btn is low; no further pulse while held.
REQ-019 SHALL clear the 32-bit divide counter to 0 on every entry to RUN, increment it each RUN cycle, and wrap it to 0 at DIV_N-1.
REQ-020 SHALL assert cpu_en in RUN on the cycle after the counter reaches DIV_N-1, so the first pulse comes DIV_N cycles after RUN entry, then one every DIV_N cycles.
REQ-021 SHALL, with DIV_N==1, hold cpu_en high on every RUN cycle after entry.
REQ-022 SHALL let halt_req in the same cycle as a due run tick suppress that tick, set halted and enter HALT.
REQ-023 SHALL clear halted only while mode==00; while halted==1, RUN entry is blocked but step mode still works.
REQ-024 SHALL give step latency of 3 CLK_in edges: step_btn first sampled high at edge k gives cpu_en high from edge k+2 to edge k+3.
REQ-025 SHALL drop a step press if mode changes away from 10 before the pulse is issued.
REQ-026 SHALL increment cycle_cnt by 1 per cpu_en cycle and wrap from 0xFFFFFFFF to 0.
REQ-027 SHALL give cnt_clr priority over increment, so cnt_clr with cpu_en gives cycle_cnt=0.
REQ-028 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-029 SHALL, while rst_n==0, asynchronously force state=HALT, cpu_en=0, halted=0, cycle_cnt=0, divide counter=0, synchronizer and edge registers=0, and debounce counter=0.
REQ-030 SHALL, on rst_n asserted mid-RUN or mid-STEP_HOLD, abort any pending pulse with no partial cpu_en; after release the block is in HALT and requires a fresh press or run request.

Configuration
REQ-031 SHALL honour macro STEP_DEBOUNCE_EN: when it is defined, a press is recognized only after the synchronized step_btn has been high for DEB_CYCLES consecutive cycles; any low sample restarts the count, and latency becomes 3+DEB_CYCLES-1 edges.
REQ-032 SHALL, when STEP_DEBOUNCE_EN is undefined, treat a press as the rising edge of the synchronized step_btn, and instantiate no debounce counter.

Verification
REQ-033 SHALL be verified by: reset low mid-RUN -> all outputs 0 and state=00 immediately; after release no cpu_en until mode/step stimulus.
REQ-034 SHALL be verified by: DIV_N=10, mode=01 for 35 cycles -> cpu_en pulses 10, 20 and 30 cycles after RUN entry, and cycle_cnt=3.
REQ-035 SHALL be verified by: mode=10, step_btn held high 50 cycles, no STEP_DEBOUNCE_EN -> exactly one cpu_en, 3 edges after the first high sample, and state=10 until release.
REQ-036 SHALL be verified by: RUN with halt_req coincident with a due tick -> no cpu_en, halted=1, state=00; mode=01 stays halted; mode=00 then 01 resumes with first pulse DIV_N cycles later.
REQ-037 SHALL be verified by: cycle_cnt preloaded via 0xFFFFFFFF pulses (or forced) then one cpu_en -> 0; cnt_clr with cpu_en -> 0.
REQ-038 SHALL be verified by: STEP_DEBOUNCE_EN, DEB_CYCLES=16, step_btn high 10 cycles, low 1, high 20 -> exactly one pulse, at 18 edges after the second rise.
